// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// The optional programmable duty cycle is enabled by defining CLK_DIV_DUTY_EN.
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF = 8;
  localparam int unsigned DIV_W_MAX = 16;
  localparam int unsigned CH_W_MAX  = 4;

  typedef logic [DIV_W_MAX-1:0] div_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_mode_e;

  typedef struct packed {
    logic [CH_W_MAX-1:0] ch;
    div_t                div;
    div_t                high;
  } cfg_req_t;

  typedef struct packed {
    div_t     p;
    div_t     div;
    div_t     high;
    ch_mode_e mode;
    logic     pend;
    div_t     pend_div;
    div_t     pend_high;
  } ch_state_t;

  function automatic div_t ceil_half(input div_t d);
    return (d >> 1) + div_t'(d[0]);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: phase counter, run/pending-update logic and registered outputs.
// Receives an already validated high time (explicit with CLK_DIV_DUTY_EN, else ceil(div/2)).
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter div_t DIV_RST = div_t'(2)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic cfg_we_i,
  input  div_t cfg_div_i,
  input  div_t cfg_high_i,
  output logic clk_o,
  output logic tick_o,
  output logic apply_o
);

  localparam div_t ONE = div_t'(1);
  localparam ch_state_t ST_RST = '{
    p:         '0,
    div:       DIV_RST,
    high:      ceil_half(DIV_RST),
    mode:      CH_IDLE,
    pend:      1'b0,
    pend_div:  '0,
    pend_high: '0
  };

  ch_state_t st_q, st_d;
  logic      clk_q, clk_d;
  logic      tick_q, tick_d;
  logic      apply;

  always_comb begin
    st_d   = st_q;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    apply  = 1'b0;

    if (!en_i) begin
      st_d.p    = '0;
      st_d.mode = CH_IDLE;
      apply     = st_q.pend;
    end else if (st_q.mode == CH_IDLE) begin
      st_d.p    = '0;
      st_d.mode = CH_RUN;
      apply     = st_q.pend;
    end else begin
      st_d.p = (st_q.p == st_q.div - ONE) ? '0 : st_q.p + ONE;
      apply  = st_q.pend && (st_d.p == '0);
    end

    // Outputs on the apply edge already use the new ratio.
    if (apply) begin
      st_d.div  = st_q.pend_div;
      st_d.high = st_q.pend_high;
      st_d.pend = 1'b0;
    end

    if (en_i) begin
      tick_d = (st_d.p == '0);
      clk_d  = (st_d.p < st_d.high);
    end

    // A request accepted on a wrap edge is only latched here; it waits for the next wrap.
    if (cfg_we_i) begin
      st_d.pend      = 1'b1;
      st_d.pend_div  = cfg_div_i;
      st_d.pend_high = cfg_high_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= ST_RST;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o   = clk_q;
  assign tick_o  = tick_q;
  assign apply_o = apply;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: config decode, global ready slot, error pulse.
// Define CLK_DIV_DUTY_EN to add cfg_high_i and a programmable per-channel high time.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned DIV_RST = 2,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
`ifdef CLK_DIV_DUTY_EN
  input  logic [DIV_W-1:0]  cfg_high_i,
`endif
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic              cfg_err_o
);

  cfg_req_t          req;
  logic              req_ok;
  logic              accept;
  logic [NUM_CH-1:0] apply;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  always_comb begin
    req      = '0;
    req.ch   = CH_W_MAX'(cfg_ch_i);
    req.div  = DIV_W_MAX'(cfg_div_i);
`ifdef CLK_DIV_DUTY_EN
    req.high = DIV_W_MAX'(cfg_high_i);
`else
    req.high = ceil_half(req.div);
`endif
    req_ok = (req.div != '0) && (32'(req.ch) < NUM_CH);
`ifdef CLK_DIV_DUTY_EN
    req_ok = req_ok && (req.high != '0) && (req.high <= req.div);
`endif
    accept  = cfg_valid_i && ready_q && req_ok;
    err_d   = cfg_valid_i && ready_q && !req_ok;
    ready_d = ready_q;
    if (accept) begin
      ready_d = 1'b0;
    end else if (|apply) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign cfg_err_o   = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .DIV_RST(DIV_W_MAX'(DIV_RST))
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i[i]),
      .cfg_we_i  (accept && (req.ch == CH_W_MAX'(i))),
      .cfg_div_i (req.div),
      .cfg_high_i(req.high),
      .clk_o     (clk_o[i]),
      .tick_o    (tick_o[i]),
      .apply_o   (apply[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (3 channels, DIV_RST=2).
// The duty-cycle section is compiled only when CLK_DIV_DUTY_EN is defined.
module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
`ifdef CLK_DIV_DUTY_EN
  logic [7:0] cfg_high;
`endif
  logic [2:0] clk_o;
  logic [2:0] tick_o;
  logic       cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH (3),
    .DIV_W  (8),
    .DIV_RST(2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_ch_i   (cfg_ch),
    .cfg_div_i  (cfg_div),
`ifdef CLK_DIV_DUTY_EN
    .cfg_high_i (cfg_high),
`endif
    .clk_o      (clk_o),
    .tick_o     (tick_o),
    .cfg_err_o  (cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] ec, input logic [2:0] et);
    @(posedge clk);
    #1;
    check({tag, ".clk"}, 32'(clk_o), 32'(ec));
    check({tag, ".tick"}, 32'(tick_o), 32'(et));
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] div);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = div;
`ifdef CLK_DIV_DUTY_EN
    cfg_high  = (div >> 1) + {7'd0, div[0]};
`endif
  endtask

  initial begin
    logic [10:0] pc;
    logic [10:0] pt;

    rst_n     = 1'b0;
    en        = 3'b000;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd0;
`ifdef CLK_DIV_DUTY_EN
    cfg_high  = 8'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst.clk", 32'(clk_o), 32'h0);
    check("rst.tick", 32'(tick_o), 32'h0);
    check("rst.err", 32'(cfg_err), 32'h0);
    check("rst.ready", 32'(cfg_ready), 32'h1);

    // div=2 on ch0, others disabled
    rst_n = 1'b1;
    en    = 3'b001;
    step("d2_e1", 3'b001, 3'b001);
    step("d2_e2", 3'b000, 3'b000);
    step("d2_e3", 3'b001, 3'b001);
    step("d2_e4", 3'b000, 3'b000);
    step("d2_e5", 3'b001, 3'b001);

    // div 2 -> 5 accepted mid-period, applied at next wrap
    send(2'd0, 8'd5);
    step("d5_acc", 3'b000, 3'b000);
    check("d5_acc.ready", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    pc = 11'b00000100111;
    pt = 11'b00000100001;
    for (int i = 0; i < 6; i++) begin
      step($sformatf("d5_p%0d", i), {2'b00, pc[i]}, {2'b00, pt[i]});
      if (i == 0) check("d5_apply.ready", 32'(cfg_ready), 32'h1);
    end
    step("d5_p6", 3'b001, 3'b000);
    step("d5_p7", 3'b001, 3'b000);
    step("d5_p8", 3'b000, 3'b000);
    step("d5_p9", 3'b000, 3'b000);

    // div 5 -> 4 accepted on the wrap edge: one more period of 5 first
    send(2'd0, 8'd4);
    step("d4_acc", 3'b001, 3'b001);
    check("d4_acc.ready", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    step("d4_o1", 3'b001, 3'b000);
    step("d4_o2", 3'b001, 3'b000);
    step("d4_o3", 3'b000, 3'b000);
    step("d4_o4", 3'b000, 3'b000);
    check("d4_wait.ready", 32'(cfg_ready), 32'h0);
    step("d4_n0", 3'b001, 3'b001);
    check("d4_apply.ready", 32'(cfg_ready), 32'h1);
    step("d4_n1", 3'b001, 3'b000);
    step("d4_n2", 3'b000, 3'b000);
    step("d4_n3", 3'b000, 3'b000);
    step("d4_n4", 3'b001, 3'b001);

    // rejected requests: div=0 and channel out of range
    send(2'd0, 8'd0);
    step("rej0", 3'b001, 3'b000);
    check("rej0.err", 32'(cfg_err), 32'h1);
    check("rej0.ready", 32'(cfg_ready), 32'h1);
    cfg_valid = 1'b0;
    step("rej0_idle", 3'b000, 3'b000);
    check("rej0_idle.err", 32'(cfg_err), 32'h0);
    send(2'd3, 8'd7);
    step("rej3", 3'b000, 3'b000);
    check("rej3.err", 32'(cfg_err), 32'h1);
    check("rej3.ready", 32'(cfg_ready), 32'h1);
    cfg_valid = 1'b0;
    step("rej_keep0", 3'b001, 3'b001);
    check("rej_keep0.err", 32'(cfg_err), 32'h0);
    step("rej_keep1", 3'b001, 3'b000);
    step("rej_keep2", 3'b000, 3'b000);
    step("rej_keep3", 3'b000, 3'b000);
    step("rej_keep4", 3'b001, 3'b001);

    // disabled ch1 gets div=3: applied on the next edge, then enabled
    send(2'd1, 8'd3);
    step("c1_acc", 3'b001, 3'b000);
    check("c1_acc.ready", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    step("c1_apply", 3'b000, 3'b000);
    check("c1_apply.ready", 32'(cfg_ready), 32'h1);
    en = 3'b011;
    step("c1_e1", 3'b010, 3'b010);
    step("c1_e2", 3'b011, 3'b001);
    step("c1_e3", 3'b001, 3'b000);
    step("c1_e4", 3'b010, 3'b010);

    // reset while an update is pending on ch0
    send(2'd0, 8'd7);
    step("rp_acc", 3'b010, 3'b000);
    check("rp_acc.ready", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rp_now.clk", 32'(clk_o), 32'h0);
    check("rp_now.tick", 32'(tick_o), 32'h0);
    check("rp_now.ready", 32'(cfg_ready), 32'h1);
    check("rp_now.err", 32'(cfg_err), 32'h0);
    step("rp_hold", 3'b000, 3'b000);
    en    = 3'b001;
    rst_n = 1'b1;
    step("rp_e1", 3'b001, 3'b001);
    check("rp_e1.ready", 32'(cfg_ready), 32'h1);
    step("rp_e2", 3'b000, 3'b000);
    step("rp_e3", 3'b001, 3'b001);
    step("rp_e4", 3'b000, 3'b000);

`ifdef CLK_DIV_DUTY_EN
    // programmable duty on ch2: high=11 > div=10 rejected, then high=3
    en        = 3'b000;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 8'd10;
    cfg_high  = 8'd11;
    step("dy_rej", 3'b000, 3'b000);
    check("dy_rej.err", 32'(cfg_err), 32'h1);
    check("dy_rej.ready", 32'(cfg_ready), 32'h1);
    cfg_high = 8'd3;
    step("dy_acc", 3'b000, 3'b000);
    check("dy_acc.err", 32'(cfg_err), 32'h0);
    check("dy_acc.ready", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    step("dy_apply", 3'b000, 3'b000);
    check("dy_apply.ready", 32'(cfg_ready), 32'h1);
    en = 3'b100;
    pc = 11'b10000000111;
    pt = 11'b10000000001;
    for (int i = 0; i < 11; i++) begin
      step($sformatf("dy_p%0d", i), {pc[i], 2'b00}, {pt[i], 2'b00});
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock divider. It is the parametrised successor of the fixed 4-way frequency divider. It generates NUM_CH independent divided clocks and period strobes from one system clock. Each channel's integer divide ratio is set at runtime through a valid/ready config port. New ratios take effect only at a period boundary, so output clocks never glitch or produce runt pulses. Outputs feed clock-enable logic and the peripheral timing blocks.

## Interface
- NUM_CH, 2: number of independent channels (1..16)
- DIV_W, 8: divisor width; legal ratio 1..2^DIV_W-1
- DIV_RST, 2: divisor loaded into every channel at reset
- clk_i  in  1  system clock, all logic on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- en_i  in  NUM_CH  per-channel run enable
- cfg_valid_i  in  1  config request
- cfg_ready_o  out  1  config slot free
- cfg_ch_i  in  max(1,$clog2(NUM_CH))  target channel
- cfg_div_i  in  DIV_W  new divide ratio
- cfg_high_i  in  DIV_W  high time in cycles (only with CLK_DIV_DUTY_EN)
- clk_o  out  NUM_CH  divided clocks, registered
- tick_o  out  NUM_CH  one-cycle strobe at start of each period, registered
- cfg_err_o  out  1  one-cycle pulse: rejected config

## Operation
- Each channel has the following state:
  - div register: reset DIV_RST
  - high register: reset ceil(DIV_RST/2)
  - phase p: reset 0
  - running flag
  - pending flag and pending value
- Reset values: clk_o=0, tick_o=0, cfg_err_o=0, cfg_ready_o=1, all pending cleared.
- Reset asserted mid-operation clears everything immediately, including pending updates.
- Channel behaviour at each clock edge:
  - en_i sampled 0: p←0, running←0, clk_o←0, tick_o←0.
  - en_i sampled 1 with running=0: p←0, running←1, tick_o←1, clk_o←(0<high).
  - en_i sampled 1 with running=1: p←(p==div-1)?0:p+1. Then tick_o←(new p==0) and clk_o←(new p<high).
- Without the macro, high=ceil(div/2). div=1 gives tick_o and clk_o constantly high while running.
- Config transfer occurs on an edge where cfg_valid_i and cfg_ready_o are both 1.
- A config is rejected if any of these hold:
  - cfg_div_i==0
  - cfg_ch_i>=NUM_CH
  - with the macro: cfg_high_i==0 or cfg_high_i>cfg_div_i
- On rejection: nothing is stored, cfg_err_o pulses the next cycle, and cfg_ready_o stays 1.
- Accepted config:
  - Stored in the channel's pending register.
  - cfg_ready_o←0 until that update is applied (single global slot).
- Applying a pending update:
  - Running channel: applied on the wrap edge (new p==0). The period starting at that edge already uses the new div/high, and clk_o/tick_o on that edge are computed with the new values.
  - Disabled channel: applied on the next edge.
- cfg_ready_o returns to 1 on the apply edge.

## Timing
- First tick_o appears one cycle after the first edge sampling en_i=1. Period is exactly div cycles.
- Config latency: from accept to apply, 1..div_old cycles. cfg_ready_o is low for that span.
- Accept and wrap on the same edge: the value is only latched, and is applied at the following wrap (div_old cycles later).
- en_i dropping while a pending update waits: the update is applied on the next edge and ready rises.
- Channels are fully independent. The relative phase between channels is fixed only by the edge on which each was enabled.

## Configuration
- CLK_DIV_DUTY_EN defined: cfg_high_i exists and is validated, and the high time is programmable per channel.
- CLK_DIV_DUTY_EN undefined: the cfg_high_i port is absent, and high=ceil(div/2), computed when the div update is applied.

## Structure
- Package clk_div_pkg holds:
  - DIV_W_DEF
  - cfg request struct (ch, div, high)
  - channel state struct
  - function ceil_half()
- Sub-module clk_div_channel contains one channel: phase counter, running/pending logic, output registers.
- The top level holds config decode/validation, the global ready flag and cfg_err_o, and generates NUM_CH channel instances.

## Test plan
- Reset with en_i=01, DIV_RST=2 -> ch0 clk_o toggles every cycle, tick_o every 2nd cycle; ch1 held 0.
- Config ch0 div=5 while running at div=2 -> ready low up to 2 cycles; then period 5 with clk_o high 3, low 2, and no pulse shorter than 1 cycle.
- Accept config ch0 div=4 on the wrap edge -> old ratio kept one more full period, then 4.
- cfg_div_i=0 and cfg_ch_i=NUM_CH -> cfg_err_o pulses once each, div unchanged, ready stays 1.
- With CLK_DIV_DUTY_EN, div=10 high=3 -> clk_o high 3 / low 7; high=11 rejected.
- rst_ni pulsed mid-period with an update pending -> outputs 0 immediately, ready 1, div back to DIV_RST.
